// File: rtl/sysid_check_ctrl.sv
// rtl/sysid_check_ctrl.sv - system-ID read/compare sequencer with CPU status/control slave
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID  = 32'd0,
    parameter logic [31:0] EXPECTED_TS  = 32'd1545046410,
    parameter int          READ_LATENCY = 0,
    parameter bit          AUTO_CHECK   = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        sysid_address,
    input  logic [31:0] sysid_readdata,
    input  logic [1:0]  ctrl_address,
    input  logic        ctrl_read,
    input  logic        ctrl_write,
    input  logic [31:0] ctrl_writedata,
    output logic [31:0] ctrl_readdata,
    output logic        id_done,
    output logic        id_ok,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_RD_TS,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  wait_cnt;
    logic [1:0]  wait_cnt_nxt;
    logic [31:0] cap_id;
    logic [31:0] cap_ts;
    logic        mm_id;
    logic        mm_ts;
    logic        irq_en;
    logic        auto_pend;

    logic        at_lat;
    logic        wr_ctrl;
    logic        start;
    logic        busy;
    logic        id_bad;
    logic        ts_bad;

    // Control-register write decode and start qualification; starts while busy are dropped.
    assign at_lat  = (wait_cnt == LAT);
    assign wr_ctrl = ctrl_write && (ctrl_address == 2'd3);
    assign start   = (state == S_IDLE) && (auto_pend || (wr_ctrl && ctrl_writedata[0]));
    assign busy    = (state != S_IDLE);
    assign id_bad  = (cap_id != EXPECTED_ID);
    assign ts_bad  = (cap_ts != EXPECTED_TS);

    // Read strobe and upper write-data bits carry no meaning for this slave.
    logic unused_ctrl;
    assign unused_ctrl = ^{ctrl_read, ctrl_writedata[31:3]};

    // State register and read-wait counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state logic; each read state holds for READ_LATENCY+1 cycles, the address follows the state.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = 2'd0;
        sysid_address = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RD_ID;
                end
            end
            S_RD_ID: begin
                if (at_lat) begin
                    state_nxt = S_RD_TS;
                end else begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            S_RD_TS: begin
                sysid_address = 1'b1;
                if (at_lat) begin
                    state_nxt = S_COMPARE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            S_COMPARE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Capture, compare and result publication; results clear when a new check starts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend <= AUTO_CHECK;
            cap_id    <= 32'd0;
            cap_ts    <= 32'd0;
            mm_id     <= 1'b0;
            mm_ts     <= 1'b0;
            id_done   <= 1'b0;
            id_ok     <= 1'b0;
        end else begin
            auto_pend <= 1'b0;
            if (start) begin
                id_done <= 1'b0;
                id_ok   <= 1'b0;
                mm_id   <= 1'b0;
                mm_ts   <= 1'b0;
            end
            if (state == S_RD_ID && at_lat) begin
                cap_id <= sysid_readdata;
            end
            if (state == S_RD_TS && at_lat) begin
                cap_ts <= sysid_readdata;
            end
            if (state == S_COMPARE) begin
                mm_id   <= id_bad;
                mm_ts   <= ts_bad;
                id_done <= 1'b1;
                id_ok   <= !id_bad && !ts_bad;
            end
        end
    end

    // Interrupt enable and sticky interrupt; a completion on the same edge beats a clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en <= ctrl_writedata[1];
            end
            if (state == S_COMPARE && irq_en) begin
                irq <= 1'b1;
            end else if (wr_ctrl && ctrl_writedata[2]) begin
                irq <= 1'b0;
            end
        end
    end

    // Zero-wait-state register read mux.
    always_comb begin
        ctrl_readdata = 32'd0;
        case (ctrl_address)
            2'd0:    ctrl_readdata = {25'd0, irq, irq_en, mm_ts, mm_id, id_ok, id_done, busy};
            2'd1:    ctrl_readdata = cap_id;
            2'd2:    ctrl_readdata = cap_ts;
            default: ctrl_readdata = {30'd0, irq_en, 1'b0};
        endcase
    end

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb/tb_sysid_check_ctrl.sv - scoreboard bench for sysid_check_ctrl
module tb_sysid_check_ctrl;

    typedef struct {
        int   done_cyc;
        logic ok;
        logic irq;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clock = ~clock;

    // Edge counter: value N after the N-th rising edge.
    always @(posedge clock) cyc <= cyc + 1;

    // Instance A: latency 0, auto check on.
    logic        a_addr;
    logic [31:0] a_rdata;
    logic [1:0]  a_caddr  = 2'd0;
    logic        a_cread  = 1'b0;
    logic        a_cwrite = 1'b0;
    logic [31:0] a_cwdata = 32'd0;
    logic [31:0] a_crdata;
    logic        a_done, a_ok, a_irq;
    logic [31:0] a_ts = 32'd1545046410;

    assign a_rdata = a_addr ? a_ts : 32'd0;

    // Instance B: latency 3, auto check off.
    logic        b_addr;
    logic [31:0] b_rdata  = 32'hDEADBEEF;
    logic [1:0]  b_caddr  = 2'd0;
    logic        b_cread  = 1'b0;
    logic        b_cwrite = 1'b0;
    logic [31:0] b_cwdata = 32'd0;
    logic [31:0] b_crdata;
    logic        b_done, b_ok, b_irq;
    int          b_age  = 0;
    logic        b_prev = 1'b0;
    bit          b_kick = 1'b0;

    sysid_check_ctrl u_dut_a (
        .clock          (clock),
        .reset_n        (reset_n),
        .sysid_address  (a_addr),
        .sysid_readdata (a_rdata),
        .ctrl_address   (a_caddr),
        .ctrl_read      (a_cread),
        .ctrl_write     (a_cwrite),
        .ctrl_writedata (a_cwdata),
        .ctrl_readdata  (a_crdata),
        .id_done        (a_done),
        .id_ok          (a_ok),
        .irq            (a_irq)
    );

    sysid_check_ctrl #(
        .READ_LATENCY (3),
        .AUTO_CHECK   (1'b0)
    ) u_dut_b (
        .clock          (clock),
        .reset_n        (reset_n),
        .sysid_address  (b_addr),
        .sysid_readdata (b_rdata),
        .ctrl_address   (b_caddr),
        .ctrl_read      (b_cread),
        .ctrl_write     (b_cwrite),
        .ctrl_writedata (b_cwdata),
        .ctrl_readdata  (b_crdata),
        .id_done        (b_done),
        .id_ok          (b_ok),
        .irq            (b_irq)
    );

    // Slow slave for B: garbage for 3 cycles after an address change or a fresh start.
    always @(negedge clock) begin
        if (b_kick || (b_addr != b_prev)) b_age = 0;
        else if (b_age < 100) b_age = b_age + 1;
        b_kick  = 1'b0;
        b_prev  = b_addr;
        b_rdata = (b_age >= 3) ? (b_addr ? 32'd1545046410 : 32'd0) : 32'hDEADBEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic pa = 1'b0;
    logic pb = 1'b0;

    // Monitor: each rising id_done pops one expected completion and checks edge, ok and irq.
    always @(negedge clock) begin
        if (a_done && !pa) begin
            if (qa.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
            else begin
                ea = qa.pop_front();
                chk("a_done_edge", cyc, ea.done_cyc);
                chk("a_ok", {31'd0, a_ok}, {31'd0, ea.ok});
                chk("a_irq", {31'd0, a_irq}, {31'd0, ea.irq});
            end
        end
        pa = a_done;
        if (b_done && !pb) begin
            if (qb.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
            else begin
                eb = qb.pop_front();
                chk("b_done_edge", cyc, eb.done_cyc);
                chk("b_ok", {31'd0, b_ok}, {31'd0, eb.ok});
                chk("b_irq", {31'd0, b_irq}, {31'd0, eb.irq});
            end
        end
        pb = b_done;
    end

    task automatic wr(input bit sel, input logic [1:0] addr, input logic [31:0] data);
        if (sel) begin b_cwrite = 1'b1; b_caddr = addr; b_cwdata = data; end
        else     begin a_cwrite = 1'b1; a_caddr = addr; a_cwdata = data; end
        @(posedge clock);
        #1;
        a_cwrite = 1'b0;
        b_cwrite = 1'b0;
    endtask

    task automatic rd(input bit sel, input logic [1:0] addr, input string name, input logic [31:0] exp);
        if (sel) b_caddr = addr;
        else     a_caddr = addr;
        #1;
        chk(name, sel ? b_crdata : a_crdata, exp);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    int k;

    initial begin
        // Reset values on both instances.
        repeat (2) @(posedge clock);
        #1;
        chk("a_rst_addr", {31'd0, a_addr}, 32'd0);
        chk("a_rst_done", {31'd0, a_done}, 32'd0);
        chk("a_rst_ok", {31'd0, a_ok}, 32'd0);
        chk("a_rst_irq", {31'd0, a_irq}, 32'd0);
        rd(0, 2'd0, "a_rst_status", 32'd0);
        rd(0, 2'd1, "a_rst_cap_id", 32'd0);
        rd(0, 2'd2, "a_rst_cap_ts", 32'd0);
        rd(0, 2'd3, "a_rst_ctrl", 32'd0);
        rd(1, 2'd0, "b_rst_status", 32'd0);

        // Auto check on A after release: first edge is the start edge, done 3 edges later.
        reset_n = 1'b1;
        k = cyc + 1;
        qa.push_back('{k + 3, 1'b1, 1'b0});
        wait_until(k + 5);
        rd(0, 2'd0, "a_status_pass", 32'h06);
        rd(0, 2'd2, "a_cap_ts_pass", 32'd1545046410);
        rd(1, 2'd0, "b_idle_no_auto", 32'd0);

        // Timestamp mismatch on A.
        a_ts = 32'd1545046411;
        wr(0, 2'd3, 32'h1);
        k = cyc;
        qa.push_back('{k + 3, 1'b0, 1'b0});
        wait_until(k + 1);
        chk("a_addr_rd_ts", {31'd0, a_addr}, 32'd1);
        rd(0, 2'd0, "a_status_busy", 32'h01);
        wait_until(k + 6);
        rd(0, 2'd0, "a_status_mm_ts", 32'h12);
        rd(0, 2'd2, "a_cap_ts_mm", 32'd1545046411);
        rd(0, 2'd1, "a_cap_id_mm", 32'd0);

        // B: software start with irq enable, latency 3, then irq clear.
        wr(1, 2'd3, 32'h3);
        k = cyc;
        b_kick = 1'b1;
        qb.push_back('{k + 9, 1'b1, 1'b1});
        wait_until(k + 12);
        wr(1, 2'd3, 32'h6);
        chk("b_irq_cleared", {31'd0, b_irq}, 32'd0);
        rd(1, 2'd0, "b_status_after_clr", 32'h26);
        rd(1, 2'd3, "b_ctrl_read", 32'h2);
        rd(1, 2'd1, "b_cap_id", 32'd0);

        // B: start during RD_TS is ignored; irq clear on the DONE edge loses to the set.
        wr(1, 2'd3, 32'h3);
        k = cyc;
        b_kick = 1'b1;
        qb.push_back('{k + 9, 1'b1, 1'b1});
        wait_until(k + 4);
        wr(1, 2'd3, 32'h3);
        wait_until(k + 8);
        wr(1, 2'd3, 32'h6);
        wait_until(k + 12);
        rd(1, 2'd0, "b_status_set_wins", 32'h66);

        // Reset pulse while A is in RD_TS.
        a_ts = 32'd1545046410;
        wr(0, 2'd3, 32'h1);
        k = cyc;
        wait_until(k + 1);
        chk("a_addr_before_rst", {31'd0, a_addr}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("a_addr_in_rst", {31'd0, a_addr}, 32'd0);
        chk("a_done_in_rst", {31'd0, a_done}, 32'd0);
        chk("b_done_in_rst", {31'd0, b_done}, 32'd0);
        chk("b_irq_in_rst", {31'd0, b_irq}, 32'd0);
        rd(0, 2'd0, "a_status_in_rst", 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        k = cyc + 1;
        qa.push_back('{k + 3, 1'b1, 1'b0});
        wait_until(k + 8);
        rd(0, 2'd0, "a_status_restart", 32'h06);
        rd(1, 2'd0, "b_status_post_rst", 32'd0);

        chk("a_queue_empty", qa.size(), 32'd0);
        chk("b_queue_empty", qb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
